// File: rtl/demux_seq_if.sv
// Demux select-sequencer bus: control inputs and demux-facing outputs.
// Master drives control, slave is the sequencer.
interface demux_seq_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic               d_in;
  logic               D;
  logic [1:0]         S;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, mode, dwell, d_in,
    input  D, S, busy, done
  );

  modport slave (
    input  start, stop, mode, dwell, d_in,
    output D, S, busy, done
  );
endinterface

// File: rtl/demux_seq.sv
// Steps a 1-to-4 demux select through 00..11 with a programmable dwell,
// routing a registered d_in onto D while running.
module demux_seq #(
  parameter int DWELL_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  demux_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic [1:0]         s_q, s_d;
  logic               d_q, d_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               term;

  assign term = (cnt_q == dwell_q - DWELL_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dwell_q <= DWELL_W'(1);
      mode_q  <= 1'b0;
      s_q     <= 2'b00;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      s_q     <= s_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    s_d     = 2'b00;
    d_d     = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          mode_d  = bus.mode;
          dwell_d = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
          cnt_d   = '0;
          busy_d  = 1'b1;
          d_d     = bus.d_in;
        end
      end
      RUN: begin
        // stop wins over both completion and continuous wrap
        if (bus.stop || (term && s_q == 2'b11 && !mode_q)) begin
          state_d = FINISH;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          d_d    = bus.d_in;
          if (term) begin
            cnt_d = '0;
            s_d   = s_q + 2'b01;
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
            s_d   = s_q;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.D    = d_q;
  assign bus.S    = s_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
